uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the team's UART transmitter link.
- Frame format matches the transmitter: one start bit (0), NBITS data bits sent MSB first, STOP_BITS stop bits (1).
- Oversamples rx at OVERSAMPLE ticks per bit, generated from clk by an internal prescaler, and samples each bit at mid-bit.
- Presents each received word with a one-cycle done pulse and flags framing errors.

Parameters:
- NBITS, 8, data bits per frame (1..16).
- STOP_BITS, 2, stop bits checked per frame (1..2).
- OVERSAMPLE, 16, ticks per bit period; even, >=4.
- CLKS_PER_TICK, 10, clk cycles per oversample tick (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_dout  output  NBITS  last correctly framed word.
- rx_done  output  1  one-cycle pulse when rx_dout is updated.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset: clk and reset are as already decided, with clk the clock and reset asynchronous, active-low. While reset is low:
  - state=IDLE; rx_dout=0; rx_done=0; frame_err=0; busy=0.
  - Synchronizer flops load 1; prescaler, tick, bit and shift counters load 0.
- Reset mid-frame aborts the frame silently: no rx_done, no frame_err.
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s, so there is 2 clk of fixed input latency.
- Prescaler: counts 0..CLKS_PER_TICK-1; tick is high for one clk when count==CLKS_PER_TICK-1, then wraps. It restarts at 0 on the IDLE->START transition, so sample points are deterministic.
- Bit period = OVERSAMPLE*CLKS_PER_TICK clk (160 by default).
- tick_cnt: width clog2(OVERSAMPLE); cleared on every state transition.
- States:
  - IDLE: busy=0. When rx_s==0, go to START.
  - START: on tick, increment tick_cnt. When tick_cnt reaches OVERSAMPLE/2-1 at a tick (mid start bit):
    - rx_s==1: glitch, return to IDLE with no outputs.
    - rx_s==0: clear tick_cnt, bit_cnt=0, go to DATA.
  - DATA: on each tick where tick_cnt==OVERSAMPLE-1 (mid data bit):
    - shift = {shift[NBITS-2:0], rx_s}, giving MSB-first assembly; bit_cnt++; tick_cnt wraps to 0.
    - After the NBITS-th sample, go to STOP with stop_cnt=0 and err=0.
  - STOP: at each mid-bit sample point (same rule as DATA):
    - If rx_s==0, set err.
    - stop_cnt++. After STOP_BITS samples, go to IDLE and, in the same clk edge:
      - err==0: rx_dout<=shift, rx_done<=1.
      - err==1: frame_err<=1; rx_dout is unchanged.
- Pulses: rx_done and frame_err are registered and high for exactly one clk. They are mutually exclusive.
- Latency: rx_done rises one clk after the last stop-bit sample edge. That is about (1 + NBITS + STOP_BITS - 0.5) bit periods plus 2 clk after the start-bit falling edge.
- Back-to-back frames: IDLE is re-entered at mid last stop bit, so a start edge arriving half a bit later is caught. No minimum idle gap is required.
- Framing error with line held low (break): after the error, the FSM returns to IDLE. It immediately sees rx_s==0 and re-enters START; each mid-bit sample of 0 produces repeated frames, each ending in frame_err. This is acceptable and not suppressed.
- rx_dout holds its value until the next good frame. There is no overrun detection, and the consumer must take the word on rx_done.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE, START, DATA, STOP);
  - default NBITS, STOP_BITS, OVERSAMPLE, CLKS_PER_TICK, so transmitter and receiver agree.
- One natural sub-module, uart_tick_gen: the prescaler producing tick, with a synchronous restart input. The transmitter can reuse it.
- Synchronizer and FSM stay in uart_receiver.

Test Plan:
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 MSB first, 2 stops), 160 clk per bit -> rx_done one pulse; rx_dout=0xA5; frame_err never high; busy low after.
- Glitch: rx low for 3 ticks (30 clk) then high -> state returns to IDLE; no rx_done; rx_dout unchanged.
- Framing error: frame 0x3C with first stop bit driven 0 -> frame_err one pulse; no rx_done; rx_dout keeps its previous value (0xA5).
- Back-to-back frames 0xFF then 0x00 with zero idle gap -> two rx_done pulses 11 bit periods (1760 clk) apart; rx_dout=0xFF then 0x00.
- Reset asserted mid DATA (after 4 bits), released, then frame 0x81 sent -> no pulses from the aborted frame; rx_done with rx_dout=0x81.
- Loopback: uart_transmitter tx wired to rx, sending 0x00, 0x55, 0xAA, 0xFF, 0x12 -> each word received in order; no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter/receiver pair.
//   - uart_state_t : frame FSM states (IDLE, START, DATA, STOP)
//   - UART_*       : default frame/timing parameters. Both ends of the link
//                    take these defaults so that they agree on the frame.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_NBITS         = 8;   // data bits per frame, MSB first
    localparam int UART_STOP_BITS     = 2;   // stop bits per frame
    localparam int UART_OVERSAMPLE    = 16;  // ticks per bit period
    localparam int UART_CLKS_PER_TICK = 10;  // clk cycles per tick

endpackage : uart_pkg

// File: rtl/uart_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
// Prescaler that divides clk down to the oversample tick rate.
// The count runs 0..CLKS_PER_TICK-1. tick is high for one clk while the
// count sits at its last value, and then the count wraps to 0.
//
// Ports
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset (count -> 0)
//   restart in   synchronous restart: count -> 0 on the next edge
//   tick    out  one-clk strobe every CLKS_PER_TICK clk
// -----------------------------------------------------------------------------
module uart_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    // A single-clk tick still needs a 1-bit counter so that it has a legal width.
    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule : uart_tick_gen

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receiver. A frame is one start bit (0), NBITS data
// bits sent MSB first, and STOP_BITS stop bits (1). rx is oversampled at
// OVERSAMPLE ticks per bit and each bit is sampled at its midpoint.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   rx_dout    out  last correctly framed word (held until the next good one)
//   rx_done    out  one-clk pulse when rx_dout is updated
//   frame_err  out  one-clk pulse when a stop bit samples 0 (rx_dout unchanged)
//   busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int NBITS         = UART_NBITS,
    parameter int STOP_BITS     = UART_STOP_BITS,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [NBITS-1:0] rx_dout,
    output logic             rx_done,
    output logic             frame_err,
    output logic             busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);  // mid start bit
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);      // one bit later
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);

    // ---------------------------------------------------------------------
    // Input synchronizer. It resets to the idle line level, so that leaving
    // reset does not look like a start edge.
    // ---------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // NOTE: use non-blocking assignments in clocked blocks. Every flop then
    // samples its pre-edge value, and the two stages cannot collapse into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Tick prescaler. It restarts when a start edge is accepted, so every
    // sample point sits at a fixed distance from that edge.
    // ---------------------------------------------------------------------
    uart_state_t state, state_n;
    logic        tick;
    logic        tick_restart;

    assign tick_restart = (state == IDLE) && !rx_s;

    uart_tick_gen #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (tick_restart),
        .tick    (tick)
    );

    // ---------------------------------------------------------------------
    // Frame FSM: the next-state/datapath logic is combinational, and all
    // state, including the output pulses, is registered below.
    // ---------------------------------------------------------------------
    logic [TW-1:0]    tick_cnt, tick_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [1:0]       stop_cnt, stop_cnt_n;
    logic             err, err_n;
    logic [NBITS-1:0] shift, shift_n;
    logic [NBITS-1:0] rx_dout_n;
    logic             rx_done_n;
    logic             frame_err_n;

    // NOTE: every signal that is written here gets its default first. A path
    // that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        err_n       = err;
        shift_n     = shift;
        rx_dout_n   = rx_dout;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            state_n = IDLE;          // line went high again: glitch
                        end else begin
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        // MSB arrives first, so shift left and append the new bit.
                        shift_n    = NBITS'({shift, rx_s});
                        bit_cnt_n  = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_n    = STOP;
                            stop_cnt_n = '0;
                            err_n      = 1'b0;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        err_n      = err | ~rx_s;
                        stop_cnt_n = stop_cnt + 2'(1);
                        // Return to IDLE at mid last stop bit, so that a start
                        // edge that follows with no idle gap is still caught.
                        if (stop_cnt == STOP_LAST) begin
                            state_n = IDLE;
                            if (err_n) begin
                                frame_err_n = 1'b1;
                            end else begin
                                rx_dout_n = shift;
                                rx_done_n = 1'b1;
                            end
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + TW'(1);
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            err       <= 1'b0;
            shift     <= '0;
            rx_dout   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            err       <= err_n;
            shift     <= shift_n;
            rx_dout   <= rx_dout_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
        end
    end

    assign busy = (state != IDLE);

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver with its default parameters (8 data bits,
// 2 stop bits, 16x oversample, 10 clk per tick -> 160 clk per bit). The
// send_frame task plays the part of the transmitter. A negedge monitor logs
// every rx_done/frame_err pulse, and the checks compare the logged values
// with expected values that are written out by hand.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BIT   = 160;          // clk per bit period
    localparam int FRAME = 11 * BIT;     // start + 8 data + 2 stop

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;

    uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_dout   (rx_dout),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pulse monitor (samples on the falling edge) ----------
    int         done_total = 0;
    int         ferr_total = 0;
    int         pulse_err  = 0;
    int         done_cyc_q[$];
    logic [7:0] word_q[$];
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;

    always @(negedge clk) begin
        if (rx_done) begin
            done_total <= done_total + 1;
            done_cyc_q.push_back(cyc);
            word_q.push_back(rx_dout);
        end
        if (frame_err) ferr_total <= ferr_total + 1;
        if ((rx_done && prev_done) || (frame_err && prev_ferr) || (rx_done && frame_err))
            pulse_err <= pulse_err + 1;
        prev_done <= rx_done;
        prev_ferr <= frame_err;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    // bad_stop: 0 = clean frame, 1/2 = that stop bit is driven low
    task automatic send_frame(input logic [7:0] d, input int bad_stop);
        drive_bit(1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        for (int s = 1; s <= 2; s++) drive_bit((bad_stop == s) ? 1'b0 : 1'b1);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        string      name;
        logic [7:0] data;
        int         bad_stop;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0, f0, base, start_cyc, lat;
        logic [7:0] exp_word;

        vecs[0] = '{"a5",        8'hA5, 0, 1, 0, 8'hA5};
        vecs[1] = '{"3c_stop1",  8'h3C, 1, 0, 1, 8'hA5};
        vecs[2] = '{"3c_stop2",  8'h3C, 2, 0, 1, 8'hA5};
        vecs[3] = '{"w00",       8'h00, 0, 1, 0, 8'h00};
        vecs[4] = '{"w55",       8'h55, 0, 1, 0, 8'h55};
        vecs[5] = '{"waa",       8'hAA, 0, 1, 0, 8'hAA};
        vecs[6] = '{"wff",       8'hFF, 0, 1, 0, 8'hFF};
        vecs[7] = '{"w12",       8'h12, 0, 1, 0, 8'h12};

        // ---- reset state ----
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout", {24'd0, rx_dout}, 32'h0);
        check("rst_done", {31'd0, rx_done}, 32'h0);
        check("rst_ferr", {31'd0, frame_err}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b1;
        idle(20);
        exp_word = 8'h00;

        // ---- table-driven single frames ----
        for (int v = 0; v < 8; v++) begin
            d0        = done_total;
            f0        = ferr_total;
            start_cyc = cyc;
            send_frame(vecs[v].data, vecs[v].bad_stop);
            idle(BIT);
            check({vecs[v].name, "_done"}, done_total - d0, vecs[v].exp_done);
            check({vecs[v].name, "_ferr"}, ferr_total - f0, vecs[v].exp_ferr);
            check({vecs[v].name, "_dout"}, {24'd0, rx_dout}, {24'd0, vecs[v].exp_dout});
            check({vecs[v].name, "_busy"}, {31'd0, busy}, 32'h0);
            if (v == 0) begin
                // About 10.5 bit periods plus synchronizer delay after the start edge.
                lat = (done_cyc_q.size() > 0) ? done_cyc_q[done_cyc_q.size() - 1] - start_cyc : -1;
                check("a5_latency_window", {31'd0, (lat >= 1675 && lat <= 1695)}, 32'h1);
            end
            exp_word = vecs[v].exp_dout;
        end

        // ---- glitch: 30 clk low, then high ----
        d0 = done_total;
        f0 = ferr_total;
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_busy_high", {31'd0, busy}, 32'h1);
        idle(BIT);
        check("glitch_done", done_total - d0, 0);
        check("glitch_ferr", ferr_total - f0, 0);
        check("glitch_busy_low", {31'd0, busy}, 32'h0);
        check("glitch_dout", {24'd0, rx_dout}, {24'd0, exp_word});

        // ---- back-to-back 0xFF then 0x00, no idle gap ----
        d0   = done_total;
        base = done_cyc_q.size();
        send_frame(8'hFF, 0);
        send_frame(8'h00, 0);
        idle(BIT);
        check("b2b_done", done_total - d0, 2);
        if (done_cyc_q.size() >= base + 2) begin
            check("b2b_gap", done_cyc_q[base + 1] - done_cyc_q[base], FRAME);
            check("b2b_word0", {24'd0, word_q[base]}, 32'hFF);
            check("b2b_word1", {24'd0, word_q[base + 1]}, 32'h00);
        end else begin
            check("b2b_pulses_seen", done_cyc_q.size() - base, 2);
        end
        check("b2b_dout", {24'd0, rx_dout}, 32'h00);

        // ---- reset in the middle of DATA, then 0x81 ----
        d0 = done_total;
        f0 = ferr_total;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (BIT / 4) @(posedge clk);
        #1;
        check("abort_busy_before", {31'd0, busy}, 32'h1);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_in_reset", {31'd0, busy}, 32'h0);
        check("abort_dout_in_reset", {24'd0, rx_dout}, 32'h0);
        reset = 1'b1;
        idle(2 * FRAME);
        check("abort_no_done", done_total - d0, 0);
        check("abort_no_ferr", ferr_total - f0, 0);
        send_frame(8'h81, 0);
        idle(BIT);
        check("x81_done", done_total - d0, 1);
        check("x81_ferr", ferr_total - f0, 0);
        check("x81_dout", {24'd0, rx_dout}, 32'h81);

        // ---- pulse shape over the whole run ----
        check("pulse_shape", pulse_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_receiver
